ps2_key_encoder: RTL and testbench

//  Receives the raw PS/2 keyboard serial stream (ps2_clk/ps2_data from the pins) and encodes it

---
 rtl/ps2_key_encoder.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// -----------------------------------------------------------------------------
// ps2_key_encoder
//
// Purpose:
//    Receives the raw PS/2 keyboard serial stream straight from the pins and
//    turns it into the 11-bit toggle-event word consumed by the input-mapping
//    logic:  [10] toggle, [9] pressed, [8] extended (E0), [7:0] scancode.
//    Bit 10 flips once per key event, so a consumer only has to watch for a
//    change in that bit (or use key_stb) to see a new event.
//
// Ports:
//    clk_sys    in   1   system clock, all logic on posedge
//    RESET      in   1   synchronous, active-high reset
//    ps2_clk    in   1   raw PS/2 clock (asynchronous to clk_sys)
//    ps2_data   in   1   raw PS/2 data  (asynchronous to clk_sys)
//    ps2_key    out  11  event word, [10] toggles once per event
//    key_stb    out  1   one-cycle pulse in the cycle ps2_key takes a new value
//    frame_err  out  1   one-cycle pulse on parity, stop-bit or timeout error
//
// Parameters:
//    FILTER_LEN   cycles the synchronized ps2_clk must disagree with the
//                 filtered level before the filtered level follows (1..255)
//    TIMEOUT_CYC  cycles without a falling edge mid-frame before the frame
//                 is abandoned
//
// Build option:
//    PS2_PAUSE_EN  when defined, the 8-byte Pause sequence
//                  (E1 14 77 E1 F0 14 F0 77) collapses into a single extended
//                  press event for scancode 77. When undefined, E1 is simply
//                  dropped and the remaining bytes decode as ordinary keys.
// -----------------------------------------------------------------------------
module ps2_key_encoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_stb,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

   // --------------------------------------------------------------------------
   // Input synchronizers and ps2_clk glitch filter
   // --------------------------------------------------------------------------
   logic       r_clk_s1;
   logic       r_clk_s2;
   logic       r_dat_s1;
   logic       r_dat_s2;
   logic       r_clk_filt;
   logic [7:0] r_filt_cnt;
   logic       w_clk_diff;
   logic       w_fall;

   assign w_clk_diff = (r_clk_s2 != r_clk_filt);
   // The filtered level flips on the FILTER_LEN-th consecutive disagreeing
   // cycle; a falling edge is that flip while the filtered level is high.
   assign w_fall     = w_clk_diff && (r_filt_cnt == FILT_LAST) && r_clk_filt;

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         // Idle PS/2 lines are high; starting high avoids a fake edge.
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_clk_filt <= 1'b1;
         r_filt_cnt <= 8'd0;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
         if (w_clk_diff) begin
            if (r_filt_cnt == FILT_LAST) begin
               r_clk_filt <= r_clk_s2;
               r_filt_cnt <= 8'd0;
            end else begin
               r_filt_cnt <= r_filt_cnt + 8'd1;
            end
         end else begin
            r_filt_cnt <= 8'd0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Frame receiver FSM (advances on filtered falling edges only)
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [2:0]    r_bitcnt;
   logic [2:0]    w_bitcnt_next;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_next;
   logic          r_par;
   logic          w_par_next;
   logic [TW-1:0] r_to_cnt;
   logic [TW-1:0] w_to_next;
   logic          w_byte_ok;
   logic          w_err;
   logic [7:0]    r_byte;
   logic          r_byte_valid;
   logic          r_frame_err;

   always_comb begin
      w_state_next  = r_state;
      w_bitcnt_next = r_bitcnt;
      w_shift_next  = r_shift;
      w_par_next    = r_par;
      w_to_next     = r_to_cnt;
      w_byte_ok     = 1'b0;
      w_err         = 1'b0;

      if (w_fall) begin
         // An edge always clears the timeout, even if it would expire now.
         w_to_next = '0;
         unique case (r_state)
            ST_IDLE: begin
               // A high "start bit" is line noise or idle; ignore it.
               if (!r_dat_s2) begin
                  w_state_next  = ST_DATA;
                  w_bitcnt_next = 3'd0;
               end
            end
            ST_DATA: begin
               w_shift_next  = {r_dat_s2, r_shift[7:1]};
               w_bitcnt_next = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  w_state_next = ST_PARITY;
               end
            end
            ST_PARITY: begin
               w_par_next   = r_dat_s2;
               w_state_next = ST_STOP;
            end
            ST_STOP: begin
               // Odd parity: data bits plus parity bit hold an odd count of 1s.
               if (r_dat_s2 && (^{r_shift, r_par})) begin
                  w_byte_ok = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
               w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end else if (r_state != ST_IDLE) begin
         if (r_to_cnt == TO_LAST) begin
            w_state_next = ST_IDLE;
            w_err        = 1'b1;
            w_to_next    = '0;
         end else begin
            w_to_next = r_to_cnt + 1'b1;
         end
      end else begin
         w_to_next = '0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         r_state      <= ST_IDLE;
         r_bitcnt     <= 3'd0;
         r_shift      <= 8'd0;
         r_par        <= 1'b0;
         r_to_cnt     <= '0;
         r_byte       <= 8'd0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_bitcnt     <= w_bitcnt_next;
         r_shift      <= w_shift_next;
         r_par        <= w_par_next;
         r_to_cnt     <= w_to_next;
         r_byte_valid <= w_byte_ok;
         r_frame_err  <= w_err;
         if (w_byte_ok) begin
            r_byte <= r_shift;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Byte decoder: prefix tracking and event generation
   // --------------------------------------------------------------------------
   logic        r_ext;
   logic        r_brk;
   logic        w_ext_next;
   logic        w_brk_next;
   logic [10:0] r_key;
   logic [10:0] w_key_next;
   logic        r_key_stb;
   logic        w_emit;
`ifdef PS2_PAUSE_EN
   logic [2:0]  r_skip_cnt;
   logic [2:0]  w_skip_next;
`endif

   always_comb begin
      w_ext_next = r_ext;
      w_brk_next = r_brk;
      w_key_next = r_key;
      w_emit     = 1'b0;
`ifdef PS2_PAUSE_EN
      w_skip_next = r_skip_cnt;
`endif

      if (w_err) begin
         // A broken frame may have been part of a prefixed sequence; never
         // let a stale prefix attach to the next key.
         w_ext_next = 1'b0;
         w_brk_next = 1'b0;
`ifdef PS2_PAUSE_EN
         w_skip_next = 3'd0;
`endif
      end else if (r_byte_valid) begin
`ifdef PS2_PAUSE_EN
         if (r_skip_cnt != 3'd0) begin
            // Swallowing the tail of the Pause sequence; the last byte
            // produces the single Pause event.
            w_skip_next = r_skip_cnt - 3'd1;
            if (r_skip_cnt == 3'd1) begin
               w_key_next = {~r_key[10], 1'b1, 1'b1, 8'h77};
               w_emit     = 1'b1;
            end
         end else if (r_byte == 8'hE1) begin
            w_skip_next = 3'd7;
            w_ext_next  = 1'b0;
            w_brk_next  = 1'b0;
         end else
`endif
         begin
            case (r_byte)
               8'hE0: w_ext_next = 1'b1;
               8'hF0: w_brk_next = 1'b1;
               // E1 (Pause lead-in) and keyboard responses carry no key.
               8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
               default: begin
                  w_key_next = {~r_key[10], ~r_brk, r_ext, r_byte};
                  w_emit     = 1'b1;
                  w_ext_next = 1'b0;
                  w_brk_next = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         r_ext     <= 1'b0;
         r_brk     <= 1'b0;
         r_key     <= 11'd0;
         r_key_stb <= 1'b0;
`ifdef PS2_PAUSE_EN
         r_skip_cnt <= 3'd0;
`endif
      end else begin
         r_ext     <= w_ext_next;
         r_brk     <= w_brk_next;
         r_key     <= w_key_next;
         r_key_stb <= w_emit;
`ifdef PS2_PAUSE_EN
         r_skip_cnt <= w_skip_next;
`endif
      end
   end

   assign ps2_key   = r_key;
   assign key_stb   = r_key_stb;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_encoder
//
// Drives PS/2 frames onto the pins, queues the expected event words as each
// stimulus is issued, and lets an independent monitor pop and compare whenever
// the DUT pulses key_stb or frame_err.
// -----------------------------------------------------------------------------
module tb_ps2_key_encoder;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 24000;
   localparam int HALF        = 30;   // clk_sys cycles per PS/2 clock half-period

   logic        clk_sys  = 1'b0;
   logic        RESET    = 1'b1;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        key_stb;
   logic        frame_err;

   always #5 clk_sys = ~clk_sys;

   ps2_key_encoder #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_sys  (clk_sys),
      .RESET    (RESET),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .key_stb  (key_stb),
      .frame_err(frame_err)
   );

   int          errors   = 0;
   int          checks   = 0;
   int          cyc      = 0;
   int          stop_cyc = 0;
   logic [10:0] model_key = 11'd0;
   logic [10:0] exp_key_q[$];
   logic [10:0] exp_err_q[$];

   always @(posedge clk_sys) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected-value model: one event word per decoded key.
   task automatic expect_key(input logic pressed, input logic ext, input logic [7:0] code);
      model_key = {~model_key[10], pressed, ext, code};
      exp_key_q.push_back(model_key);
      $display("queue event %h (pressed=%0d ext=%0d code=%h)", model_key, pressed, ext, code);
   endtask

   // A frame error must leave the event word untouched.
   task automatic expect_err();
      exp_err_q.push_back(model_key);
      $display("queue frame error, ps2_key must hold %h", model_key);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_sys);
   endtask

   // Sends the first nbits of a frame: start, 8 data LSB first, parity, stop.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11);
   endtask

   // ---------------------------------------------------------------- monitor
   logic prev_stb = 1'b0;
   logic prev_err = 1'b0;

   always @(negedge clk_sys) begin
      if (!RESET) begin
         if (key_stb) begin
            check("stb_one_cycle", {31'd0, prev_stb}, 32'd0);
            check("stb_latency", {31'd0, ((cyc - stop_cyc) >= 2) && ((cyc - stop_cyc) <= 20)}, 32'd1);
            if (exp_key_q.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected_event: got %h expected no event", ps2_key);
            end else begin
               logic [10:0] e;
               e = exp_key_q.pop_front();
               $display("event ps2_key=%h expected %h", ps2_key, e);
               check("event_word", {21'd0, ps2_key}, {21'd0, e});
            end
         end
         if (frame_err) begin
            check("err_one_cycle", {31'd0, prev_err}, 32'd0);
            if (exp_err_q.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected_frame_err: got pulse expected none");
            end else begin
               logic [10:0] e;
               e = exp_err_q.pop_front();
               $display("frame_err ps2_key=%h expected hold %h", ps2_key, e);
               check("err_key_hold", {21'd0, ps2_key}, {21'd0, e});
            end
         end
      end
      prev_stb = key_stb;
      prev_err = frame_err;
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      wait_cyc(5);
      RESET = 1'b0;
      @(negedge clk_sys);
      check("reset_key", {21'd0, ps2_key}, 32'd0);
      check("reset_stb", {31'd0, key_stb}, 32'd0);
      check("reset_err", {31'd0, frame_err}, 32'd0);

      // Plain make code.
      expect_key(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);

      // Extended release, both prefix orders.
      expect_key(1'b0, 1'b1, 8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      expect_key(1'b0, 1'b1, 8'h74);
      send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h74);

      // Bad parity, then the same byte good.
      expect_err();
      send_frame(8'h29, 1'b1, 1'b0, 11);
      expect_key(1'b1, 1'b0, 8'h29);
      send_byte(8'h29);

      // Bad stop bit, then the same byte good.
      expect_err();
      send_frame(8'h5A, 1'b0, 1'b1, 11);
      expect_key(1'b1, 1'b0, 8'h5A);
      send_byte(8'h5A);

      // E0 then a truncated frame: timeout must drop the frame and the prefix.
      send_byte(8'hE0);
      expect_err();
      send_frame(8'h12, 1'b0, 1'b0, 6);
      wait_cyc(TIMEOUT_CYC + 200);
      expect_key(1'b1, 1'b0, 8'h16);
      send_byte(8'h16);

      // Keyboard responses are dropped silently.
      send_byte(8'hFA); send_byte(8'hAA); send_byte(8'hEE); send_byte(8'hFE);
      expect_key(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);

      // Short ps2_clk glitches in IDLE must be filtered out.
      for (int g = 0; g < 3; g++) begin
         ps2_clk = 1'b0;
         wait_cyc(FILTER_LEN - 2);
         ps2_clk = 1'b1;
         wait_cyc(20);
      end
      expect_key(1'b1, 1'b0, 8'h33);
      send_byte(8'h33);

      // A parity error clears a pending E0 prefix.
      send_byte(8'hE0);
      expect_err();
      send_frame(8'h44, 1'b1, 1'b0, 11);
      expect_key(1'b1, 1'b0, 8'h6B);
      send_byte(8'h6B);

      // Pause sequence.
`ifdef PS2_PAUSE_EN
      expect_key(1'b1, 1'b1, 8'h77);
`else
      expect_key(1'b1, 1'b0, 8'h14);
      expect_key(1'b1, 1'b0, 8'h77);
      expect_key(1'b0, 1'b0, 8'h14);
      expect_key(1'b0, 1'b0, 8'h77);
`endif
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);

      wait_cyc(100);
      check("events_outstanding", exp_key_q.size(), 32'd0);
      check("errs_outstanding", exp_err_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
